// File: rtl/alu_pkg.sv
// Shared ALU operation codes and multicycle FSM states.
// Used by the ALU controller, alu_comb and multicycle_alu.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_LUI = 4'b1010,
    OP_SLT = 4'b1110
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } aluState_t;

  localparam int SHAMT_WIDTH = 5;

  function automatic logic isShiftOp(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath. Shift codes pass SrcA through; the multicycle
// wrapper only routes them here when the shift amount is zero.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic [DATA_WIDTH-1:0] result
);

  // Unknown codes fall through to zero.
  always_comb begin
    result = '0;
    case (Operation)
      OP_AND:  result = SrcA & SrcB;
      OP_OR:   result = SrcA | SrcB;
      OP_ADD:  result = SrcA + SrcB;
      OP_SUB:  result = SrcA - SrcB;
      OP_XOR:  result = SrcA ^ SrcB;
      OP_SRL:  result = SrcA;
      OP_SLL:  result = SrcA;
      OP_SRA:  result = SrcA;
      OP_EQ:   result[0] = (SrcA == SrcB);
      OP_LUI:  result = SrcB;
      OP_SLT:  result[0] = ($signed(SrcA) < $signed(SrcB));
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops finish in one cycle, shifts iterate one
// bit per cycle on a captured accumulator before reporting done.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  aluState_t               state, nextState;
  logic [DATA_WIDTH-1:0]   acc, accNext, shifted;
  logic [SHAMT_WIDTH-1:0]  count, countNext;
  logic [3:0]              opReg, opNext;
  logic [DATA_WIDTH-1:0]   combResult, resultNext;
  logic                    loadResult;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) uComb (
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .result    (combResult)
  );

  // One-bit step of the latched shift; operates only on captured state.
  always_comb begin
    shifted = acc;
    case (opReg)
      OP_SLL:  shifted = {acc[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc[DATA_WIDTH-1:1]};
      OP_SRA:  shifted = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      default: shifted = acc;
    endcase
  end

  always_comb begin
    nextState  = state;
    accNext    = acc;
    countNext  = count;
    opNext     = opReg;
    loadResult = 1'b0;
    resultNext = ALUResult;
    case (state)
      IDLE: begin
        if (start) begin
          if (isShiftOp(Operation) && (SrcB[SHAMT_WIDTH-1:0] != '0)) begin
            accNext   = SrcA;
            countNext = SrcB[SHAMT_WIDTH-1:0];
            opNext    = Operation;
            nextState = SHIFT;
          end else begin
            loadResult = 1'b1;
            resultNext = combResult;
            nextState  = DONE;
          end
        end
      end
      SHIFT: begin
        accNext   = shifted;
        countNext = count - SHAMT_WIDTH'(1);
        // The last step publishes the shifted value as it leaves SHIFT.
        if (count == SHAMT_WIDTH'(1)) begin
          loadResult = 1'b1;
          resultNext = shifted;
          nextState  = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      opReg     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      state <= nextState;
      acc   <= accNext;
      count <= countNext;
      opReg <= opNext;
      if (loadResult) begin
        ALUResult <= resultNext;
        Zero      <= (resultNext == '0);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-005 The block SHALL have port Operation, input, 4, ALU operation code from the ALU controller.
REQ-006 The block SHALL have port SrcA, input, DATA_WIDTH, first operand.
REQ-007 The block SHALL have port SrcB, input, DATA_WIDTH, second operand; SrcB[4:0] is the shift amount.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking ALUResult and Zero valid.
REQ-010 The block SHALL have port ALUResult, output, DATA_WIDTH, registered result.
REQ-011 The block SHALL have port Zero, output, 1, registered flag, high when ALUResult equals 0.

Function
REQ-012 Operation decode SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B); 0100 XOR; 0101 SRL; 0110 SLL; 0111 SRA; 1000 EQ ({0..,A==B}); 1010 LUI-pass (result=SrcB); 1110 SLT signed ({0..,A<B}).
REQ-013 Any other Operation code SHALL produce ALUResult 0 with normal latency 1.
REQ-014 The FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 In IDLE with start=1 and a non-shift code, or a shift code with SrcB[4:0]=0, the block SHALL register the result and go to DONE (done in cycle N+1).
REQ-016 In IDLE with start=1, a shift code and SrcB[4:0]=k>0, the block SHALL latch SrcA into an accumulator, load a 5-bit counter with k, and go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL shift the accumulator one bit (SLL zero-fill left, SRL zero-fill right, SRA sign-fill right) and decrement the counter; when the counter reaches 0 the state SHALL go to DONE, so done asserts in cycle N+1+k.
REQ-018 Operands SHALL be captured at start; SrcA/SrcB/Operation changes during SHIFT SHALL not affect the result.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored (no queueing).
REQ-021 ALUResult and Zero SHALL hold their values from the last done until the next done.
REQ-022 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; no overflow output.

Reset
REQ-023 On reset=1 at a clock edge, the state SHALL become IDLE and busy=0, done=0, ALUResult=0, Zero=1, counter=0, accumulator=0.
REQ-024 Reset in SHIFT or DONE SHALL abort the operation with no done pulse; reset SHALL dominate a simultaneous start.

Structure
REQ-025 Operation codes and the state enum SHALL live in shared package alu_pkg, also used by the ALU controller.
REQ-026 Single-cycle operations SHALL be in combinational sub-module alu_comb; shift iteration and FSM stay in multicycle_alu.

Verification
REQ-027 ADD: A=5, B=7, start for one cycle -> done at cycle N+1, ALUResult=12, Zero=0.
REQ-028 SUB: A=B=0x1234 -> ALUResult=0, Zero=1; SLT: A=0xFFFFFFFF, B=1 -> ALUResult=1.
REQ-029 SRA: A=0x80000000, B=4 -> busy for 5 cycles, done at N+5, ALUResult=0xF8000000; SLL with B=0 -> done at N+1, ALUResult=A.
REQ-030 SLL: A=1, B=31, start re-asserted and operands changed mid-shift -> one done at N+32, ALUResult=0x80000000, extra starts ignored.
REQ-031 Reset asserted at SHIFT cycle 3 of SRL A=0xF0, B=8 -> next cycle IDLE, busy=0, ALUResult=0, Zero=1, no done pulse.
REQ-032 Undefined Operation 1111 with A=3, B=4 -> done at N+1, ALUResult=0, Zero=1.
